// File: rtl/rfft_seq.sv
`default_nettype none
// ============================================================================
// Module   : rfft_seq
// Purpose  : Stage sequencer for the 64x4-bank in-place radix-2 real FFT.
//            On start it walks the shared PE through NSTAGE butterfly stages.
//            Each stage is a READ sweep of 2^ADDR_W counter values followed by
//            a drain. Every read is mirrored into a write pipeline D = PE_LAT+1
//            deep, so each write lands exactly D cycles after its read.
// Ports    : clk, rst_n (async, active low), start, abort        - control in
//            busy, done, stage                                    - status out
//            rd_en, rd_addr0, rd_addr1, rd_swap, tf_addr, bypass_n - read side
//            wr_en[3:0], wr_addr0, wr_addr1, wr_swap              - write side
// Revision : 1.0 - initial release
// ============================================================================
module rfft_seq #(
  parameter int ADDR_W = 6,
  parameter int NSTAGE = 7,
  parameter int PE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [2:0]        stage,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic              rd_swap,
  output logic [ADDR_W-1:0] tf_addr,
  output logic              bypass_n,
  output logic [3:0]        wr_en,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [ADDR_W-1:0] wr_addr1,
  output logic              wr_swap
);

  // Write delay: PE latency plus one cycle of bank read latency.
  localparam int          D     = PE_LAT + 1;
  localparam int          DW    = $clog2(D + 1);
  localparam logic [2:0]  LAST  = 3'(NSTAGE - 1);
  localparam logic [2:0]  AW3   = 3'(ADDR_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DW-1:0]     dcnt;

  // Write pipeline: entry 0 takes the current read, entry D-1 drives the banks.
  logic              p_v   [D];
  logic [ADDR_W-1:0] p_a0  [D];
  logic [ADDR_W-1:0] p_a1  [D];
  logic              p_sw  [D];

  // Read-side decode, all from registered cnt/stage/state.
  logic [ADDR_W-1:0] addr1_mask;
  logic [2:0]        rsel;
  logic [2:0]        wsel;
  logic [ADDR_W-1:0] rshift;
  logic [ADDR_W-1:0] wshift;
  logic              wswap;

  // Top `stage` bits of the counter are inverted to form the partner address.
  assign addr1_mask = ~({ADDR_W{1'b1}} >> stage);
  assign rsel       = AW3 - stage;
  assign wsel       = AW3 - 3'd1 - stage;
  assign rshift     = cnt >> rsel;
  assign wshift     = cnt >> wsel;
  assign wswap      = (stage == LAST) ? 1'b0 : wshift[0];

  assign busy     = (state == S_READ) || (state == S_DRAIN);
  assign done     = (state == S_DONE);
  assign rd_en    = (state == S_READ);
  assign rd_addr0 = cnt;
  assign rd_addr1 = cnt ^ addr1_mask;
  assign rd_swap  = (stage == 3'd0) ? 1'b0 : rshift[0];
  assign tf_addr  = cnt << stage;
  // Multiply is skipped only while the last stage is actually running.
  assign bypass_n = !(busy && (stage == LAST));

  assign wr_en    = {4{p_v[D-1]}};
  assign wr_addr0 = p_a0[D-1];
  assign wr_addr1 = p_a1[D-1];
  assign wr_swap  = p_sw[D-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      stage <= '0;
      dcnt  <= '0;
      for (int i = 0; i < D; i++) begin
        p_v[i]  <= 1'b0;
        p_a0[i] <= '0;
        p_a1[i] <= '0;
        p_sw[i] <= 1'b0;
      end
    end else begin
      // The pipeline shifts in every state so the last write of a stage
      // retires during the final drain cycle.
      p_v[0]  <= (state == S_READ);
      p_a0[0] <= rd_addr0;
      p_a1[0] <= rd_addr1;
      p_sw[0] <= wswap;
      for (int i = 1; i < D; i++) begin
        p_v[i]  <= p_v[i-1];
        p_a0[i] <= p_a0[i-1];
        p_a1[i] <= p_a1[i-1];
        p_sw[i] <= p_sw[i-1];
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_READ;
            cnt   <= '0;
            stage <= '0;
          end
        end

        S_READ: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
            stage <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == {ADDR_W{1'b1}}) begin
              state <= S_DRAIN;
              dcnt  <= DW'(D - 1);
            end
          end
        end

        S_DRAIN: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
            stage <= '0;
          end else if (dcnt == '0) begin
            if (stage != LAST) begin
              stage <= stage + 3'd1;
              cnt   <= '0;
              state <= S_READ;
            end else begin
              state <= S_DONE;
            end
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          stage <= '0;
        end

        default: state <= S_IDLE;
      endcase

      // Aborted transforms must not commit any writes still in flight.
      if (busy && abort) begin
        for (int i = 0; i < D; i++) p_v[i] <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rfft_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rfft_seq
// Purpose  : Self-checking bench for rfft_seq. A cycle-indexed reference model
//            derives every expected output from the stage/counter schedule
//            with plain arithmetic; a vector table pins hand-computed points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rfft_seq;

  localparam int D   = 3;
  localparam int L   = 64 + D;
  localparam int NS  = 7;
  localparam int TOT = NS * L;   // last busy cycle
  localparam int PER = TOT + 2;  // cycle distance between starts when held

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       busy, done, rd_en, rd_swap, bypass_n, wr_swap;
  logic [2:0] stage;
  logic [5:0] rd_addr0, rd_addr1, tf_addr, wr_addr0, wr_addr1;
  logic [3:0] wr_en;

  rfft_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_swap(rd_swap), .tf_addr(tf_addr), .bypass_n(bypass_n),
    .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_swap(wr_swap)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int         s;
    int         c;
    logic [5:0] a1;
    logic       rsw;
    logic [5:0] tf;
    logic       byp;
    logic       wsw;
  } vec_t;

  vec_t tbl[7];

  localparam logic [63:0] RST_MASK = 64'h7FF_FFFF_FFFF;
  localparam logic [63:0] RST_EXP  = 64'h000_0200_0000;

  task automatic check(string nm, int k, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, k, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_a1(int s, int c);
    return c ^ (64 - (64 >> s));
  endfunction

  function automatic int ref_rswap(int s, int c);
    return (s == 0) ? 0 : ((c >> (6 - s)) & 1);
  endfunction

  function automatic int ref_wswap(int s, int c);
    return (s == 6) ? 0 : ((c >> (5 - s)) & 1);
  endfunction

  function automatic bit is_read(int k, output int s, output int c);
    s = 0; c = 0;
    if (k < 1 || k > TOT) return 1'b0;
    s = (k - 1) / L;
    c = (k - 1) % L;
    return c < 64;
  endfunction

  // k = cycles since the start edge (k=1 is the first READ cycle).
  task automatic model(int k, output logic [63:0] e, output logic [63:0] m);
    int s, c, ws, wc, st;
    bit rd, wr, bz, dn;
    e = '0; m = '0;
    rd = is_read(k, s, c);
    wr = is_read(k - D, ws, wc);
    bz = (k >= 1) && (k <= TOT);
    dn = (k == TOT + 1);
    st = bz ? (k - 1) / L : 0;
    m[1:0] = 2'b11;   e[0] = bz; e[1] = dn;
    m[5] = 1'b1;      e[5] = rd;
    m[29:26] = 4'hF;  e[29:26] = wr ? 4'hF : 4'h0;
    if (bz) begin m[4:2] = 3'h7; e[4:2] = 3'(st); end
    if (rd) begin
      m[24:6]  = '1;
      e[11:6]  = 6'(c);
      e[17:12] = 6'(ref_a1(s, c));
      e[18]    = 1'(ref_rswap(s, c));
      e[24:19] = 6'((c * (1 << s)) % 64);
    end
    if (!dn) begin m[25] = 1'b1; e[25] = bz ? (st != 6) : 1'b1; end
    if (wr) begin
      m[42:30] = '1;
      e[35:30] = 6'(wc);
      e[41:36] = 6'(ref_a1(ws, wc));
      e[42]    = 1'(ref_wswap(ws, wc));
    end
  endtask

  function automatic logic [63:0] dut_vec();
    logic [63:0] v;
    v = '0;
    v[0] = busy; v[1] = done; v[4:2] = stage; v[5] = rd_en;
    v[11:6] = rd_addr0; v[17:12] = rd_addr1; v[18] = rd_swap;
    v[24:19] = tf_addr; v[25] = bypass_n; v[29:26] = wr_en;
    v[35:30] = wr_addr0; v[41:36] = wr_addr1; v[42] = wr_swap;
    return v;
  endfunction

  task automatic check_model(string nm, int kdisp, int kmodel);
    logic [63:0] e, m;
    model(kmodel, e, m);
    check(nm, kdisp, dut_vec() & m, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after an edge; that cycle becomes cycle 0 (start asserted).
  task automatic run_full(string nm, bit noise, bit use_tbl);
    int nwr = 0, nbusy = 0, ndone = 0;
    start = 1'b1;
    for (int k = 1; k <= TOT + 3; k++) begin
      tick();
      check_model(nm, k, k);
      if (wr_en == 4'hF) nwr++;
      if (busy) nbusy++;
      if (done) ndone++;
      if (use_tbl) begin
        for (int i = 0; i < 7; i++) begin
          int kr;
          kr = 1 + L * tbl[i].s + tbl[i].c;
          if (k == kr)
            check("tbl_rd", k,
                  {35'd0, stage, rd_en, rd_addr0, rd_addr1, rd_swap, tf_addr, bypass_n},
                  {35'd0, 3'(tbl[i].s), 1'b1, 6'(tbl[i].c), tbl[i].a1, tbl[i].rsw,
                   tbl[i].tf, tbl[i].byp});
          if (k == kr + D)
            check("tbl_wr", k, {45'd0, wr_en, wr_addr0, wr_addr1, wr_swap},
                  {45'd0, 4'hF, 6'(tbl[i].c), tbl[i].a1, tbl[i].wsw});
        end
      end
      start = (noise && k <= TOT) ? 1'($urandom_range(0, 5) == 0) : 1'b0;
    end
    check({nm, "_wr_count"}, 0, 64'(nwr), 64'(NS * 64));
    check({nm, "_busy_count"}, 0, 64'(nbusy), 64'(TOT));
    check({nm, "_done_count"}, 0, 64'(ndone), 64'd1);
  endtask

  // Abort driven in cycle a; returns in cycle a+2 with the bench idle.
  task automatic run_abort(string nm, int a, bit start_too);
    start = 1'b1;
    for (int k = 1; k <= a; k++) begin
      tick();
      check_model(nm, k, k);
      start = 1'b0;
    end
    abort = 1'b1;
    start = start_too;
    for (int k = a + 1; k <= a + 2; k++) begin
      tick();
      abort = 1'b0;
      start = 1'b0;
      check_model({nm, "_idle"}, k, 0);
    end
  endtask

  initial begin
    tbl[0] = '{2,  5, 6'd53, 1'b0, 6'd20, 1'b1, 1'b0};
    tbl[1] = '{6, 10, 6'd53, 1'b0, 6'd0,  1'b0, 1'b0};
    tbl[2] = '{0, 63, 6'd63, 1'b0, 6'd63, 1'b1, 1'b1};
    tbl[3] = '{1, 40, 6'd8,  1'b1, 6'd16, 1'b1, 1'b0};
    tbl[4] = '{3, 13, 6'd53, 1'b1, 6'd40, 1'b1, 1'b1};
    tbl[5] = '{5,  7, 6'd57, 1'b1, 6'd32, 1'b1, 1'b1};
    tbl[6] = '{4,  0, 6'd60, 1'b0, 6'd0,  1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    #1;
    check("reset_vals", 0, dut_vec() & RST_MASK, RST_EXP);
    tick(); tick();
    check("reset_vals", 0, dut_vec() & RST_MASK, RST_EXP);
    rst_n = 1'b1;
    tick();
    check_model("idle", 0, 0);

    // Full transform with the vector table.
    run_full("basic", 1'b0, 1'b1);

    // Abort in stage 1 READ with a simultaneous start, then restart in 102.
    run_abort("abort100", 100, 1'b1);
    run_full("after_abort", 1'b0, 1'b0);

    // start held high: a new transform every PER cycles, none while busy.
    start = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      tick();
      check_model("hold", k, ((k - 1) % PER) + 1);
    end
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check_model("hold_abort_idle", 0, 0);

    // Reset pulse during stage 4 DRAIN.
    start = 1'b1;
    for (int k = 1; k <= 4 * L + 65; k++) begin
      tick();
      check_model("pre_rst", k, k);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("rst_async", 0, dut_vec() & RST_MASK, RST_EXP);
    tick();
    check("rst_low", 0, dut_vec() & RST_MASK, RST_EXP);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_model("post_rst_idle", k, 0);
    end

    // Randomized sequences: idle gaps, noisy start pulses, random aborts.
    for (int it = 0; it < 4; it++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        tick();
        check_model("rnd_gap", g, 0);
      end
      if ($urandom_range(0, 1) == 1) run_full("rnd_full", 1'b1, 1'b0);
      else run_abort("rnd_abort", $urandom_range(1, TOT), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rfft_seq.md
# rfft_seq

Stage sequencer for the 64×4-bank in-place radix-2 real FFT datapath. It accepts a start request, then steps the shared PE through 7 butterfly stages. For each stage it issues bank read addresses, the operand swap select, the twiddle address and bypass control. It delays the PE result with a write pipeline that drives bank write addresses, enables and the result swap select. It ends each stage with a drain so that no stage reads data still in flight, and reports completion with busy/done.

## Interface
- ADDR_W, 6, bank address width; 2^ADDR_W words per bank
- NSTAGE, 7, number of butterfly stages; stage index width 3
- PE_LAT, 2, PE input-to-output latency in cycles; write delay D = PE_LAT+1, including 1 cycle of BRAM read latency
---
- Clk  in  1  clock; all logic on rising edge
- Reset_n  in  1  asynchronous active-low reset
- start  in  1  request a full transform; sampled only in IDLE
- abort  in  1  cancel a running transform; ignored in IDLE
- busy  out  1  high from the first READ cycle through the last DRAIN cycle
- done  out  1  single-cycle completion pulse
- stage  out  3  current stage, 0..NSTAGE-1
- rd_en  out  1  bank read strobe
- rd_addr0  out  ADDR_W  read address, banks 0/1
- rd_addr1  out  ADDR_W  read address, banks 2/3
- rd_swap  out  1  PE operand swap select, aligned with rd_en
- tf_addr  out  ADDR_W  twiddle ROM address, aligned with rd_en
- bypass_n  out  1  0 = PE passes operands without multiply
- wr_en  out  4  per-bank write enables
- wr_addr0  out  ADDR_W  write address, banks 0/1
- wr_addr1  out  ADDR_W  write address, banks 2/3
- wr_swap  out  1  result swap select into the banks

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE + start=1 -> READ. At that edge: cnt=0, stage=0.
- READ: rd_en=1 and cnt increments each cycle. When cnt=63 -> DRAIN, with drain counter = D-1.
- DRAIN: rd_en=0. Drain counter decrements. At 0:
  - if stage<NSTAGE-1: stage+1, cnt=0, -> READ;
  - otherwise -> DONE.
- DONE: done=1 for one cycle, then -> IDLE.
- abort=1 in READ or DRAIN -> IDLE next edge. Write pipeline valid bits clear; done is not asserted. start in the same cycle is ignored.
- start while not IDLE is ignored.
- Read address generation, for stage s and counter c:
  - rd_addr0 = c.
  - rd_addr1 = c with its top s bits inverted.
  - s=0: rd_addr1 = c. s=6: rd_addr1 = ~c.
- rd_swap: 0 for s=0, otherwise c[6-s].
- tf_addr = (c << s) truncated to ADDR_W.
- bypass_n = 0 only in stage 6; 1 otherwise, including IDLE.
- Write pipeline is D deep and carries {valid, rd_addr0, rd_addr1, wswap}.
  - wswap = c[5-s] for s<6; 0 for s=6.
  - Outputs come from the last pipeline register: wr_en = {4{valid}}, wr_addr0/1, wr_swap.
- The pipeline shifts every cycle in all states, so the last write of a stage lands in the final DRAIN cycle.

## Timing
- Reset values: busy=0, done=0, stage=0, rd_en=0, rd_addr0/1=0, rd_swap=0, tf_addr=0, bypass_n=1, wr_en=0, wr_addr0/1=0, wr_swap=0. All pipeline valid bits=0.
- All outputs are registered or decoded from registered state only; there are no combinational paths from input to output.
- Let the start edge be cycle 0:
  - first read is in cycle 1;
  - per stage: 64 READ + D DRAIN cycles;
  - busy is high in cycles 1..7·(64+D); with defaults, 1..469;
  - done=1 in cycle 7·(64+D)+1 (470), with busy=0.
- Read-to-write latency is exactly D cycles: a read issued in cycle t writes in cycle t+D, with the same addresses.
- stage changes on the edge between the last DRAIN cycle and the next stage's first READ cycle. It never changes while rd_en=1.
- Counter wrap: cnt never exceeds 63. It restarts at 0 each stage.
- A back-to-back start is accepted only in the IDLE cycle after DONE, giving a minimum 2-cycle gap between busy periods.
- Reset asserted mid-transform forces all reset values immediately; any in-flight writes are discarded.

## Test plan
- Reset, then start pulse in cycle 0 with defaults -> busy high in cycles 1..469; done=1 in cycle 470 only; exactly 7·64=448 cycles with wr_en=4'hF.
- Stage 2, cnt=5 -> rd_addr0=5, rd_addr1=53, rd_swap=0, tf_addr=20; 3 cycles later wr_addr0=5, wr_addr1=53, wr_en=4'hF, wr_swap=0 (c[3]=0).
- Stage 6, cnt=10 -> rd_addr1=53, rd_swap=0, tf_addr=0, bypass_n=0; wr_swap=0 on the matching write.
- abort in cycle 100 (stage 1 READ) -> IDLE in cycle 101; wr_en=0 from 101 on; no done pulse; a new start in 102 restarts at stage 0, cnt 0.
- start held high continuously -> second busy period begins in cycle 472; no start is accepted while busy.
- Reset_n low for 1 cycle during stage 4 DRAIN -> all outputs at reset values while low; wr_en stays 0 after release until a new start.
